// File: rtl/jtag_cmd_pkg.sv
// Shared command/status encodings and FSM state type for the JTAG command master.
package jtag_cmd_pkg;

  localparam logic [7:0] CMD_NOP    = 8'h00;
  localparam logic [7:0] CMD_WRITE  = 8'h01;
  localparam logic [7:0] CMD_READ   = 8'h02;

  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_BADCMD  = 8'h01;
  localparam logic [7:0] ST_TIMEOUT = 8'h02;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_BUS,
    S_RESP_STAT,
    S_RESP_DATA
  } state_e;

endpackage

// File: rtl/jtag_cmd_master.sv
// Byte-stream command engine: decodes WRITE/READ packets from the bridge, runs one bus beat,
// streams status/read data back. Define JTAG_CMD_TIMEOUT_EN to enable the bus ack timeout.
module jtag_cmd_master
  import jtag_cmd_pkg::*;
#(
  parameter int ADDR_BYTES     = 4,
  parameter int DATA_BYTES     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [7:0]              i_rx_data,
  input  logic                    i_rx_avail,
  output logic                    o_rx_read,
  output logic [7:0]              o_tx_data,
  output logic                    o_tx_write,
  input  logic                    i_tx_ready,
  output logic                    o_bus_req,
  output logic                    o_bus_we,
  output logic [8*ADDR_BYTES-1:0] o_bus_addr,
  output logic [8*DATA_BYTES-1:0] o_bus_wdata,
  input  logic                    i_bus_ack,
  input  logic [8*DATA_BYTES-1:0] i_bus_rdata
);

  localparam int AW   = 8 * ADDR_BYTES;
  localparam int DW   = 8 * DATA_BYTES;
  localparam int MAXB = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int CW   = (MAXB > 1) ? $clog2(MAXB) : 1;
  localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_BYTES - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BYTES - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [7:0]      status_q, status_d;
  logic [DW-1:0]   rdata_sh;

`ifdef JTAG_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0]   tmo_q, tmo_d;
`endif

  // Response bytes leave MSB first: shift the selected byte to the top.
  assign rdata_sh    = rdata_q << {cnt_q, 3'b000};
  assign o_bus_we    = we_q;
  assign o_bus_addr  = addr_q;
  assign o_bus_wdata = wdata_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      status_q <= ST_OK;
`ifdef JTAG_CMD_TIMEOUT_EN
      tmo_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      status_q <= status_d;
`ifdef JTAG_CMD_TIMEOUT_EN
      tmo_q    <= tmo_d;
`endif
    end
  end

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    status_d   = status_q;
    o_rx_read  = 1'b0;
    o_tx_write = 1'b0;
    o_tx_data  = 8'h00;
    o_bus_req  = 1'b0;
`ifdef JTAG_CMD_TIMEOUT_EN
    tmo_d      = '0;
`endif

    unique case (state_q)
      S_IDLE: begin
        o_rx_read = i_rx_avail;
        if (i_rx_avail) begin
          cnt_d = '0;
          unique case (i_rx_data)
            CMD_NOP:   ;
            CMD_WRITE: begin we_d = 1'b1; state_d = S_ADDR; end
            CMD_READ:  begin we_d = 1'b0; state_d = S_ADDR; end
            default:   begin status_d = ST_BADCMD; state_d = S_RESP_STAT; end
          endcase
        end
      end

      S_ADDR: begin
        o_rx_read = i_rx_avail;
        if (i_rx_avail) begin
          addr_d = AW'({addr_q, i_rx_data});
          if (cnt_q == ADDR_LAST) begin
            cnt_d   = '0;
            state_d = we_q ? S_WDATA : S_BUS;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_WDATA: begin
        o_rx_read = i_rx_avail;
        if (i_rx_avail) begin
          wdata_d = DW'({wdata_q, i_rx_data});
          if (cnt_q == DATA_LAST) begin
            cnt_d   = '0;
            state_d = S_BUS;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_BUS: begin
        o_bus_req = 1'b1;
        if (i_bus_ack) begin
          rdata_d  = i_bus_rdata;
          status_d = ST_OK;
          state_d  = S_RESP_STAT;
        end
`ifdef JTAG_CMD_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          status_d = ST_TIMEOUT;
          state_d  = S_RESP_STAT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end

      S_RESP_STAT: begin
        o_tx_data  = status_q;
        o_tx_write = i_tx_ready;
        if (i_tx_ready) begin
          cnt_d   = '0;
          state_d = (!we_q && status_q == ST_OK) ? S_RESP_DATA : S_IDLE;
        end
      end

      S_RESP_DATA: begin
        o_tx_data  = rdata_sh[DW-1 -: 8];
        o_tx_write = i_tx_ready;
        if (i_tx_ready) begin
          if (cnt_q == DATA_LAST) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule
